rr_stage: RTL and testbench

- Register-read stage directly downstream of the ID/RR pipeline register.
- Holds the 8x32 architectural register file and a per-register pending-write scoreboard.
- Generates the RAW/WAW hazard stall back to ID/RR and drives the RR/EX pipeline register.
- Bypasses same-cycle writeback data to its source operands.

---
 rtl/rr_stage_pkg.sv | 30 +++
 rtl/rr_stage_if.sv | 43 ++++
 rtl/rr_scoreboard.sv | 72 +++++++
 rtl/rr_stage.sv | 98 +++++++++
 tb/tb_rr_stage.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/rr_stage_pkg.sv
// Shared constants for the register-read stage: register file geometry,
// ctrl-field bit positions and the pending-counter helpers.
package rr_stage_pkg;

  localparam int NREGS  = 8;
  localparam int IDX_W  = 3;
  localparam int PEND_W = 2;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 7;

  // ctrl_in bit positions
  localparam int REG_WRITE  = 0;
  localparam int USES_SRC1  = 1;
  localparam int USES_SRC2  = 2;
  localparam int USE_IMM    = 3;
  localparam int ALU_OP_LSB = 4;

  localparam logic [PEND_W-1:0] PEND_ZERO = '0;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  // A used source is blocked while writers are in flight, unless the only
  // outstanding writer is retiring this very cycle (its data gets bypassed).
  function automatic logic src_hazard(input logic              uses,
                                      input logic [PEND_W-1:0] pend,
                                      input logic              wb_hit);
    return uses && (pend != PEND_ZERO) && !((pend == PEND_ONE) && wb_hit);
  endfunction

endpackage

// File: rtl/rr_stage_if.sv
// ID/RR input bundle, writeback port and RR/EX output bundle of rr_stage.
interface rr_stage_if;
  import rr_stage_pkg::*;

  logic              valid_in;
  logic [DATA_W-1:0] pc_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [IDX_W-1:0]  dst_idx_in;
  logic [IDX_W-1:0]  src1_idx_in;
  logic [IDX_W-1:0]  src2_idx_in;
  logic [DATA_W-1:0] imm_in;
  logic [2:0]        instr_length_in;
  logic              stall_in;
  logic              flush;
  logic              wb_valid;
  logic [IDX_W-1:0]  wb_idx;
  logic [DATA_W-1:0] wb_data;

  logic              stall_out;
  logic              valid_out;
  logic [DATA_W-1:0] pc_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [IDX_W-1:0]  dst_idx_out;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        instr_length_out;
  logic              sb_err;

  modport master (
    output valid_in, pc_in, ctrl_in, dst_idx_in, src1_idx_in, src2_idx_in,
           imm_in, instr_length_in, stall_in, flush, wb_valid, wb_idx, wb_data,
    input  stall_out, valid_out, pc_out, ctrl_out, dst_idx_out, op_a, op_b,
           instr_length_out, sb_err
  );

  modport slave (
    input  valid_in, pc_in, ctrl_in, dst_idx_in, src1_idx_in, src2_idx_in,
           imm_in, instr_length_in, stall_in, flush, wb_valid, wb_idx, wb_data,
    output stall_out, valid_out, pc_out, ctrl_out, dst_idx_out, op_a, op_b,
           instr_length_out, sb_err
  );

endinterface

// File: rtl/rr_scoreboard.sv
// Per-register pending-write counters, RAW/WAW hazard detection with
// same-cycle writeback bypass, stall/issue generation and sticky sb_err.
module rr_scoreboard
  import rr_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             reg_write_i,
  input  logic             uses_src1_i,
  input  logic             uses_src2_i,
  input  logic [IDX_W-1:0] dst_idx_i,
  input  logic [IDX_W-1:0] src1_idx_i,
  input  logic [IDX_W-1:0] src2_idx_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             wb_valid_i,
  input  logic [IDX_W-1:0] wb_idx_i,
  output logic             hz_o,
  output logic             stall_o,
  output logic             issue_o,
  output logic             sb_err_o
);

  logic [NREGS-1:0][PEND_W-1:0] pend_q;
  logic [NREGS-1:0][PEND_W-1:0] pend_d;
  logic [NREGS-1:0]             err_hit;
  logic                         err_q;
  logic                         src1_hz;
  logic                         src2_hz;
  logic                         sat_hz;

  // Hazard, stall and issue decisions for the instruction sitting in ID/RR.
  always_comb begin
    src1_hz  = src_hazard(uses_src1_i, pend_q[src1_idx_i],
                          wb_valid_i && (wb_idx_i == src1_idx_i));
    src2_hz  = src_hazard(uses_src2_i, pend_q[src2_idx_i],
                          wb_valid_i && (wb_idx_i == src2_idx_i));
    sat_hz   = reg_write_i && (pend_q[dst_idx_i] == PEND_MAX);
    hz_o     = valid_i && (src1_hz || src2_hz || sat_hz);
    stall_o  = !flush_i && (hz_o || stall_i);
    issue_o  = valid_i && !stall_o && !flush_i;
  end

  // Saturation stalls keep inc from ever being applied at PEND_MAX, so the
  // increment needs no clamp; a decrement at zero is a stray writeback.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
    logic inc;
    logic dec;
    assign inc         = issue_o && reg_write_i && (dst_idx_i == IDX_W'(gi));
    assign dec         = wb_valid_i && (wb_idx_i == IDX_W'(gi));
    assign err_hit[gi] = dec && (pend_q[gi] == PEND_ZERO);
    assign pend_d[gi]  = flush_i                                    ? PEND_ZERO :
                         (inc && !dec)                              ? pend_q[gi] + PEND_ONE :
                         (dec && !inc && pend_q[gi] != PEND_ZERO)   ? pend_q[gi] - PEND_ONE :
                                                                      pend_q[gi];
  end

  // Pending counters and the sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (|err_hit) err_q <= 1'b1;
    end
  end

  assign sb_err_o = err_q;

endmodule

// File: rtl/rr_stage.sv
// Register-read stage: 8x32 register file with writeback bypass, operand
// selection, and the RR/EX pipeline register, gated by the scoreboard.
module rr_stage
  import rr_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  rr_stage_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] src1_val;
  logic [DATA_W-1:0] src2_val;
  logic              hz;
  logic              issue;

  logic              valid_q;
  logic [DATA_W-1:0] pc_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [IDX_W-1:0]  dst_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [2:0]        len_q;

  rr_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (bus.valid_in),
    .reg_write_i (bus.ctrl_in[REG_WRITE]),
    .uses_src1_i (bus.ctrl_in[USES_SRC1]),
    .uses_src2_i (bus.ctrl_in[USES_SRC2]),
    .dst_idx_i   (bus.dst_idx_in),
    .src1_idx_i  (bus.src1_idx_in),
    .src2_idx_i  (bus.src2_idx_in),
    .stall_i     (bus.stall_in),
    .flush_i     (bus.flush),
    .wb_valid_i  (bus.wb_valid),
    .wb_idx_i    (bus.wb_idx),
    .hz_o        (hz),
    .stall_o     (bus.stall_out),
    .issue_o     (issue),
    .sb_err_o    (bus.sb_err)
  );

  // Register file: writeback always commits, regardless of stall or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (bus.wb_valid) begin
      regs_q[bus.wb_idx] <= bus.wb_data;
    end
  end

  // Source operands see same-cycle writeback data ahead of the array.
  always_comb begin
    src1_val = (bus.wb_valid && bus.wb_idx == bus.src1_idx_in) ? bus.wb_data
                                                               : regs_q[bus.src1_idx_in];
    src2_val = (bus.wb_valid && bus.wb_idx == bus.src2_idx_in) ? bus.wb_data
                                                               : regs_q[bus.src2_idx_in];
  end

  // RR/EX register: flush kills, downstream stall holds, hazard bubbles.
  // On capture, valid_q follows valid_in, which equals issue in that branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      ctrl_q  <= '0;
      dst_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      len_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (bus.stall_in) begin
      valid_q <= valid_q;
    end else if (hz) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= issue;
      pc_q    <= bus.pc_in;
      ctrl_q  <= bus.ctrl_in;
      dst_q   <= bus.dst_idx_in;
      op_a_q  <= src1_val;
      op_b_q  <= bus.ctrl_in[USE_IMM] ? bus.imm_in : src2_val;
      len_q   <= bus.instr_length_in;
    end
  end

  assign bus.valid_out        = valid_q;
  assign bus.pc_out           = pc_q;
  assign bus.ctrl_out         = ctrl_q;
  assign bus.dst_idx_out      = dst_q;
  assign bus.op_a             = op_a_q;
  assign bus.op_b             = op_b_q;
  assign bus.instr_length_out = len_q;

endmodule

// File: tb/tb_rr_stage.sv
// Self-checking bench for rr_stage: a reference model predicts stall_out
// each cycle and the RR/EX contents one edge later via an expected queue.
module tb_rr_stage;

  logic clk;
  logic rst;

  rr_stage_if bus ();

  rr_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  ctrl;
    logic [2:0]  dst;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  len;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_out;
  logic [31:0] m_regs [8];
  int          m_pend [8];
  logic        m_err;
  logic [31:0] pc_ctr;
  int          n_checks;
  int          n_errors;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
    m_out = '{valid: 1'b0, pc: '0, ctrl: '0, dst: '0, a: '0, b: '0, len: '0, err: 1'b0};
    exp_q.delete();
  endtask

  task automatic drive_idle();
    bus.valid_in = 0; bus.pc_in = '0; bus.ctrl_in = '0; bus.dst_idx_in = '0;
    bus.src1_idx_in = '0; bus.src2_idx_in = '0; bus.imm_in = '0;
    bus.instr_length_in = '0; bus.stall_in = 0; bus.flush = 0;
    bus.wb_valid = 0; bus.wb_idx = '0; bus.wb_data = '0;
  endtask

  // One clock of stimulus: drive, predict, check stall, then check RR/EX.
  task automatic step(input logic vin, input logic [6:0] ctrl, input logic [2:0] dst,
                      input logic [2:0] s1, input logic [2:0] s2, input logic [31:0] imm,
                      input logic sin, input logic fl,
                      input logic wbv, input logic [2:0] wbi, input logic [31:0] wbd);
    logic [31:0] v1, v2;
    logic h1, h2, sat, hz, stall, issue;
    exp_t e;
    @(negedge clk);
    pc_ctr = pc_ctr + 32'd4;
    bus.valid_in = vin; bus.pc_in = pc_ctr; bus.ctrl_in = ctrl; bus.dst_idx_in = dst;
    bus.src1_idx_in = s1; bus.src2_idx_in = s2; bus.imm_in = imm;
    bus.instr_length_in = pc_ctr[4:2]; bus.stall_in = sin; bus.flush = fl;
    bus.wb_valid = wbv; bus.wb_idx = wbi; bus.wb_data = wbd;
    #1;
    v1  = (wbv && wbi == s1) ? wbd : m_regs[s1];
    v2  = (wbv && wbi == s2) ? wbd : m_regs[s2];
    h1  = ctrl[1] && m_pend[s1] != 0 && !(m_pend[s1] == 1 && wbv && wbi == s1);
    h2  = ctrl[2] && m_pend[s2] != 0 && !(m_pend[s2] == 1 && wbv && wbi == s2);
    sat = ctrl[0] && m_pend[dst] == 3;
    hz  = vin && (h1 || h2 || sat);
    stall = fl ? 1'b0 : (hz || sin);
    issue = vin && !stall && !fl;
    chk("stall_out", {31'd0, bus.stall_out}, {31'd0, stall});
    // next RR/EX contents
    if (fl)       m_out.valid = 1'b0;
    else if (sin) m_out.valid = m_out.valid;
    else if (hz)  m_out.valid = 1'b0;
    else begin
      m_out.valid = vin; m_out.pc = pc_ctr; m_out.ctrl = ctrl; m_out.dst = dst;
      m_out.a = v1; m_out.b = ctrl[3] ? imm : v2; m_out.len = pc_ctr[4:2];
    end
    // pending counters, error flag, register file
    for (int r = 0; r < 8; r++) begin
      bit inc, dec;
      inc = issue && ctrl[0] && dst == 3'(r);
      dec = wbv && wbi == 3'(r);
      if (dec && m_pend[r] == 0) m_err = 1'b1;
      if (fl) m_pend[r] = 0;
      else if (inc && !dec) m_pend[r] = m_pend[r] + 1;
      else if (dec && !inc && m_pend[r] != 0) m_pend[r] = m_pend[r] - 1;
    end
    if (wbv) m_regs[wbi] = wbd;
    m_out.err = m_err;
    exp_q.push_back(m_out);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      $display("t=%0t vin=%0b ctrl=%02h dst=%0d s1=%0d s2=%0d sin=%0b fl=%0b wb=%0b/%0d/%08h -> stall=%0b valid_out=%0b op_a=%08h op_b=%08h err=%0b",
               $time, vin, ctrl, dst, s1, s2, sin, fl, wbv, wbi, wbd, stall,
               bus.valid_out, bus.op_a, bus.op_b, bus.sb_err);
      chk("valid_out", {31'd0, bus.valid_out}, {31'd0, e.valid});
      chk("sb_err", {31'd0, bus.sb_err}, {31'd0, e.err});
      if (e.valid) begin
        chk("pc_out", bus.pc_out, e.pc);
        chk("ctrl_out", {25'd0, bus.ctrl_out}, {25'd0, e.ctrl});
        chk("dst_idx_out", {29'd0, bus.dst_idx_out}, {29'd0, e.dst});
        chk("op_a", bus.op_a, e.a);
        chk("op_b", bus.op_b, e.b);
        chk("instr_length_out", {29'd0, bus.instr_length_out}, {29'd0, e.len});
      end
    end
  endtask

  task automatic wb_only(input logic [2:0] idx, input logic [31:0] data);
    step(0, 7'h00, 3'd0, 3'd0, 3'd0, 32'd0, 0, 0, 1, idx, data);
  endtask

  task automatic issue_op(input logic [6:0] ctrl, input logic [2:0] dst,
                          input logic [2:0] s1, input logic [2:0] s2, input logic [31:0] imm);
    step(1, ctrl, dst, s1, s2, imm, 0, 0, 0, 3'd0, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd0);
    chk({tag, "_pc"}, bus.pc_out, 32'd0);
    chk({tag, "_op_a"}, bus.op_a, 32'd0);
    chk({tag, "_op_b"}, bus.op_b, 32'd0);
    chk({tag, "_ctrl"}, {25'd0, bus.ctrl_out}, 32'd0);
    chk({tag, "_sb_err"}, {31'd0, bus.sb_err}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    pc_ctr   = 32'h0000_1000;
    drive_idle();
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    chk("reset_stall_out", {31'd0, bus.stall_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: preload r1=5, r2=7, then ADD r3 <- r1,r2; then an immediate form
    wb_only(3'd1, 32'd5);
    wb_only(3'd2, 32'd7);
    issue_op(7'h07, 3'd3, 3'd1, 3'd2, 32'd0);
    issue_op(7'h1B, 3'd7, 3'd2, 3'd0, 32'h0000_00AA);

    // 2: RAW on r3 (pending from ADD) until wb r3=0xDEAD arrives
    issue_op(7'h03, 3'd6, 3'd3, 3'd0, 32'd0);
    issue_op(7'h03, 3'd6, 3'd3, 3'd0, 32'd0);
    step(1, 7'h03, 3'd6, 3'd3, 3'd0, 32'd0, 0, 0, 1, 3'd3, 32'h0000_DEAD);

    // 3: same-cycle bypass on r4, then r4 no longer pending
    issue_op(7'h01, 3'd4, 3'd0, 3'd0, 32'd0);
    step(1, 7'h03, 3'd0, 3'd4, 3'd0, 32'd0, 0, 0, 1, 3'd4, 32'h0000_1234);
    issue_op(7'h02, 3'd0, 3'd4, 3'd0, 32'd0);

    // 4: WAW saturation on r5
    issue_op(7'h01, 3'd5, 3'd0, 3'd0, 32'd0);
    issue_op(7'h01, 3'd5, 3'd0, 3'd0, 32'd0);
    issue_op(7'h01, 3'd5, 3'd0, 3'd0, 32'd0);
    issue_op(7'h01, 3'd5, 3'd0, 3'd0, 32'd0);
    issue_op(7'h01, 3'd5, 3'd0, 3'd0, 32'd0);
    step(1, 7'h01, 3'd5, 3'd0, 3'd0, 32'd0, 0, 0, 1, 3'd5, 32'h55);
    issue_op(7'h01, 3'd5, 3'd0, 3'd0, 32'd0);
    wb_only(3'd5, 32'h56);
    step(1, 7'h01, 3'd5, 3'd0, 3'd0, 32'd0, 0, 0, 1, 3'd5, 32'h57);
    issue_op(7'h01, 3'd5, 3'd0, 3'd0, 32'd0);
    issue_op(7'h01, 3'd5, 3'd0, 3'd0, 32'd0);

    // 5: downstream stall holds RR/EX for 3 cycles
    issue_op(7'h07, 3'd2, 3'd1, 3'd3, 32'd0);
    for (int i = 0; i < 3; i++)
      step(1, 7'h0F, 3'd1, 3'd2, 3'd0, 32'hBEEF, 1, 0, 0, 3'd0, 32'd0);
    issue_op(7'h0F, 3'd1, 3'd2, 3'd0, 32'hBEEF);

    // Mid-operation asynchronous reset
    @(negedge clk);
    drive_idle();
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // 6: flush with pend[1]=2 and wb r1=9, then stray wb to r2
    issue_op(7'h01, 3'd1, 3'd0, 3'd0, 32'd0);
    issue_op(7'h01, 3'd1, 3'd0, 3'd0, 32'd0);
    step(1, 7'h03, 3'd6, 3'd1, 3'd0, 32'd0, 0, 1, 1, 3'd1, 32'd9);
    issue_op(7'h02, 3'd0, 3'd1, 3'd0, 32'd0);
    wb_only(3'd2, 32'h22);
    issue_op(7'h00, 3'd0, 3'd0, 3'd0, 32'd0);
    step(0, 7'h00, 3'd0, 3'd0, 3'd0, 32'd0, 0, 0, 0, 3'd0, 32'd0);

    // Randomised mix against the model
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           32'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
